// File: rtl/rpu_ibd_pkt_tracker_pkg.sv
// nou_ibd_pkg: shared definitions for the inbound packet tracker.
// Holds flit type codes, error codes, context states and the header
// field layout of a HEAD flit payload. NoC width macros get defaults
// here when the surrounding build has not already supplied them.
`ifndef NOU_FLIT_SZ_WIDTH
`define NOU_FLIT_SZ_WIDTH 12
`endif
`ifndef NOU_TID_WIDTH
`define NOU_TID_WIDTH 8
`endif
`ifndef NOU_TYPE_WIDTH
`define NOU_TYPE_WIDTH 2
`endif
`ifndef NOU_NOC_DATA_WIDTH
`define NOU_NOC_DATA_WIDTH 128
`endif

package nou_ibd_pkg;

  localparam int TID_W  = `NOU_TID_WIDTH;
  localparam int TYPE_W = `NOU_TYPE_WIDTH;
  localparam int DATA_W = `NOU_NOC_DATA_WIDTH;

  // Flit type codes; code 0 is reserved and ignored by the tracker
  localparam logic [TYPE_W-1:0] FLIT_HEAD = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] FLIT_BODY = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] FLIT_TAIL = TYPE_W'(3);

  typedef enum logic [1:0] {
    ERR_DUP_HEAD = 2'b00,
    ERR_ORPHAN   = 2'b01,
    ERR_LENGTH   = 2'b10
  } err_code_e;

  typedef enum logic {
    CTX_IDLE   = 1'b0,
    CTX_ACTIVE = 1'b1
  } ctx_state_e;

  // Header bit positions inside a HEAD flit payload
  localparam int LOCAL_TILE_LSB = 0;
  localparam int LOCAL_TILE_W   = 10;
  localparam int DST_TILE_LSB   = 10;
  localparam int DST_TILE_W     = 10;
  localparam int FLIT_NUM_LSB   = 20;
  localparam int FLIT_NUM_W     = 12;
  localparam int HDR_SIZE_LSB   = 32;
  localparam int HDR_SIZE_W     = 8;
  localparam int DATA_SIZE_LSB  = 40;
  localparam int DATA_SIZE_W    = 6;
  localparam int PKT_ID_LSB     = 64;
  localparam int PKT_ID_W       = 32;

  typedef struct packed {
    logic [PKT_ID_W-1:0]     pkt_id;
    logic [DATA_SIZE_W-1:0]  data_size;
    logic [HDR_SIZE_W-1:0]   header_size;
    logic [FLIT_NUM_W-1:0]   flit_num;
    logic [DST_TILE_W-1:0]   dst_tile_id;
    logic [LOCAL_TILE_W-1:0] local_tile_id;
  } hdr_fields_t;

endpackage

// File: rtl/rpu_ibd_pkt_tracker_ctx.sv
// rpu_ibd_ctx: one packet context (IDLE/ACTIVE FSM, remaining-flit
// counter, stored tid). Emits combinational event strobes for the flit
// being accepted this cycle; the top registers them.
`ifndef NOU_FLIT_SZ_WIDTH
`define NOU_FLIT_SZ_WIDTH 12
`endif

module rpu_ibd_ctx
  import nou_ibd_pkg::*;
#(
  parameter int CNT_W = `NOU_FLIT_SZ_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flit_acc,
  input  logic [TYPE_W-1:0]     flit_type,
  input  logic [FLIT_NUM_W-1:0] flit_num,
  input  logic [TID_W-1:0]      flit_tid,
  output logic                  busy,
  output logic [TID_W-1:0]      tid,
  output logic                  hdr_ev,
  output logic                  done_ev,
  output logic                  err_ev,
  output err_code_e             err_code_ev
);

  ctx_state_e       state_reg, state_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [TID_W-1:0] tid_reg, tid_next;

  // Context state, counter and tid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CTX_IDLE;
      remaining_reg <= '0;
      tid_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      tid_reg       <= tid_next;
    end
  end

  // Next-state and event decode for the flit accepted this cycle
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    tid_next       = tid_reg;
    hdr_ev         = 1'b0;
    done_ev        = 1'b0;
    err_ev         = 1'b0;
    err_code_ev    = ERR_DUP_HEAD;
    if (flit_acc) begin
      case (flit_type)
        FLIT_HEAD: begin
          // A head on a live context abandons the old packet
          hdr_ev   = 1'b1;
          tid_next = flit_tid;
          if (state_reg == CTX_ACTIVE) begin
            err_ev      = 1'b1;
            err_code_ev = ERR_DUP_HEAD;
          end
          if (flit_num >= FLIT_NUM_W'(2)) begin
            state_next     = CTX_ACTIVE;
            remaining_next = CNT_W'(flit_num - FLIT_NUM_W'(1));
          end else begin
            // Single-flit packet completes on its head
            state_next     = CTX_IDLE;
            remaining_next = '0;
            done_ev        = 1'b1;
          end
        end
        FLIT_BODY: begin
          if (state_reg == CTX_IDLE) begin
            err_ev      = 1'b1;
            err_code_ev = ERR_ORPHAN;
          end else if (remaining_reg == CNT_W'(1)) begin
            // Body where only the tail was still expected
            err_ev         = 1'b1;
            err_code_ev    = ERR_LENGTH;
            state_next     = CTX_IDLE;
            remaining_next = '0;
          end else if (remaining_reg != '0) begin
            remaining_next = remaining_reg - CNT_W'(1);
          end
        end
        FLIT_TAIL: begin
          if (state_reg == CTX_IDLE) begin
            err_ev      = 1'b1;
            err_code_ev = ERR_ORPHAN;
          end else begin
            state_next     = CTX_IDLE;
            remaining_next = '0;
            if (remaining_reg == CNT_W'(1)) begin
              done_ev = 1'b1;
            end else begin
              err_ev      = 1'b1;
              err_code_ev = ERR_LENGTH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg == CTX_ACTIVE);
  assign tid  = tid_reg;

endmodule

// File: rtl/rpu_ibd_pkt_tracker.sv
// rpu_ibd_pkt_tracker: tracks inbound NoC packets per transaction
// context, reporting headers, completions and protocol errors one cycle
// after the flit is accepted.
// Optional feature macro RPU_IBD_ERR_CNT_EN adds a saturating err_cnt.
`ifndef NOU_FLIT_SZ_WIDTH
`define NOU_FLIT_SZ_WIDTH 12
`endif

module rpu_ibd_pkt_tracker
  import nou_ibd_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int CNT_W   = `NOU_FLIT_SZ_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic                       id_ready,
  input  logic [TID_W-1:0]           id_dat_tid,
  input  logic [TYPE_W-1:0]          id_dat_type,
  input  logic [DATA_W-1:0]          id_dat_data,
  output logic                       hdr_vld,
  output logic [$clog2(NUM_CTX)-1:0] hdr_ctx,
  output logic [TID_W-1:0]           hdr_tid,
  output logic [LOCAL_TILE_W-1:0]    hdr_local_tile_id,
  output logic [DST_TILE_W-1:0]      hdr_dst_tile_id,
  output logic [PKT_ID_W-1:0]        hdr_pkt_id,
  output logic [HDR_SIZE_W-1:0]      hdr_header_size,
  output logic [DATA_SIZE_W-1:0]     hdr_data_size,
  output logic [FLIT_NUM_W-1:0]      hdr_flit_num,
  output logic                       pkt_done,
  output logic [$clog2(NUM_CTX)-1:0] pkt_done_ctx,
  output logic                       err_vld,
  output logic [1:0]                 err_code,
`ifdef RPU_IBD_ERR_CNT_EN
  output logic [15:0]                err_cnt,
`endif
  output logic [NUM_CTX-1:0]         ctx_busy
);

  localparam int IDX_W = $clog2(NUM_CTX);

  logic                           flit_acc;
  logic [IDX_W-1:0]               ctx_idx;
  logic [NUM_CTX-1:0]             hdr_ev_vec, done_ev_vec, err_ev_vec;
  logic [NUM_CTX-1:0][1:0]        err_code_vec;
  logic [NUM_CTX-1:0][TID_W-1:0]  ctx_tid_vec;
  logic [1:0]                     err_code_any;
  hdr_fields_t                    hdr_dec;

  logic             hdr_vld_reg, pkt_done_reg, err_vld_reg;
  logic [1:0]       err_code_reg;
  logic [IDX_W-1:0] hdr_ctx_reg, pkt_done_ctx_reg;
  hdr_fields_t      hdr_reg;

  assign flit_acc = id_valid & id_ready;
  assign ctx_idx  = id_dat_tid[IDX_W-1:0];

  // Upper tid bits alias onto the same context by design
  for (genvar gi = 0; gi < NUM_CTX; gi++) begin : g_ctx
    rpu_ibd_ctx #(
      .CNT_W(CNT_W)
    ) u_ctx (
      .clk        (clk),
      .rst        (rst),
      .flit_acc   (flit_acc && (ctx_idx == IDX_W'(gi))),
      .flit_type  (id_dat_type),
      .flit_num   (id_dat_data[FLIT_NUM_LSB +: FLIT_NUM_W]),
      .flit_tid   (id_dat_tid),
      .busy       (ctx_busy[gi]),
      .tid        (ctx_tid_vec[gi]),
      .hdr_ev     (hdr_ev_vec[gi]),
      .done_ev    (done_ev_vec[gi]),
      .err_ev     (err_ev_vec[gi]),
      .err_code_ev(err_code_vec[gi])
    );
  end

  // Only one context sees a flit per cycle, so pick the erroring one
  always_comb begin
    err_code_any = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (err_ev_vec[i]) err_code_any = err_code_vec[i];
    end
  end

  // Slice header fields out of the incoming payload
  always_comb begin
    hdr_dec               = '0;
    hdr_dec.local_tile_id = id_dat_data[LOCAL_TILE_LSB +: LOCAL_TILE_W];
    hdr_dec.dst_tile_id   = id_dat_data[DST_TILE_LSB +: DST_TILE_W];
    hdr_dec.flit_num      = id_dat_data[FLIT_NUM_LSB +: FLIT_NUM_W];
    hdr_dec.header_size   = id_dat_data[HDR_SIZE_LSB +: HDR_SIZE_W];
    hdr_dec.data_size     = id_dat_data[DATA_SIZE_LSB +: DATA_SIZE_W];
    hdr_dec.pkt_id        = id_dat_data[PKT_ID_LSB +: PKT_ID_W];
  end

  // Register event pulses and hold header fields until the next head
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_vld_reg      <= 1'b0;
      pkt_done_reg     <= 1'b0;
      err_vld_reg      <= 1'b0;
      err_code_reg     <= '0;
      hdr_ctx_reg      <= '0;
      pkt_done_ctx_reg <= '0;
      hdr_reg          <= '0;
    end else begin
      hdr_vld_reg  <= |hdr_ev_vec;
      pkt_done_reg <= |done_ev_vec;
      err_vld_reg  <= |err_ev_vec;
      err_code_reg <= err_code_any;
      if (|hdr_ev_vec) begin
        hdr_reg     <= hdr_dec;
        hdr_ctx_reg <= ctx_idx;
      end
      if (|done_ev_vec) pkt_done_ctx_reg <= ctx_idx;
    end
  end

`ifdef RPU_IBD_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  // Saturating count of reported errors, updated alongside err_vld
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if ((|err_ev_vec) && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

  // Payload bits outside the header layout are not needed here
  logic unused_data;
  assign unused_data = ^{id_dat_data[DATA_W-1:PKT_ID_LSB+PKT_ID_W],
                         id_dat_data[PKT_ID_LSB-1:DATA_SIZE_LSB+DATA_SIZE_W]};

  assign hdr_vld           = hdr_vld_reg;
  assign hdr_ctx           = hdr_ctx_reg;
  assign hdr_tid           = ctx_tid_vec[hdr_ctx_reg];
  assign hdr_local_tile_id = hdr_reg.local_tile_id;
  assign hdr_dst_tile_id   = hdr_reg.dst_tile_id;
  assign hdr_pkt_id        = hdr_reg.pkt_id;
  assign hdr_header_size   = hdr_reg.header_size;
  assign hdr_data_size     = hdr_reg.data_size;
  assign hdr_flit_num      = hdr_reg.flit_num;
  assign pkt_done          = pkt_done_reg;
  assign pkt_done_ctx      = pkt_done_ctx_reg;
  assign err_vld           = err_vld_reg;
  assign err_code          = err_code_reg;

endmodule

// File: doc/rpu_ibd_pkt_tracker.md
RPU_IBD_PKT_TRACKER -- requirements
Module: rpu_ibd_pkt_tracker

Interface
REQ-001 Parameter NUM_CTX, default 4, number of per-transaction packet contexts (power of 2, 2..16).
REQ-002 Parameter CNT_W, default `NOU_FLIT_SZ_WIDTH, width of the remaining-flit counter.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 id_valid, id_ready  in  1 each  inbound router handshake; a flit is accepted when both are high.
REQ-006 id_dat_tid  in  `NOU_TID_WIDTH  transaction id; context index = low log2(NUM_CTX) bits.
REQ-007 id_dat_type  in  `NOU_TYPE_WIDTH  flit type: HEAD, BODY or TAIL.
REQ-008 id_dat_data  in  `NOU_NOC_DATA_WIDTH  flit payload.
REQ-009 hdr_vld  out  1  one-cycle pulse, header fields below are valid.
REQ-010 hdr_ctx, hdr_tid, hdr_local_tile_id, hdr_dst_tile_id, hdr_pkt_id, hdr_header_size, hdr_data_size, hdr_flit_num  out  package widths  registered header fields.
REQ-011 pkt_done  out  1  one-cycle pulse, packet completed; pkt_done_ctx  out  log2(NUM_CTX)  its context.
REQ-012 err_vld  out  1  one-cycle pulse; err_code  out  2  00 dup-head, 01 orphan, 10 length.
REQ-013 ctx_busy  out  NUM_CTX  per-context active bitmap.

Function
REQ-014 Header field extraction: local_tile_id=data[9:0], dst_tile_id=data[19:10], flit_num=data[31:20], header_size=data[39:32], data_size=data[45:40], pkt_id=data[95:64].
REQ-015 Each context: FSM IDLE/ACTIVE, remaining counter (CNT_W), stored tid.
REQ-016 Accepted HEAD, context IDLE: hdr_vld next cycle; flit_num>=2 -> ACTIVE, remaining=flit_num-1; flit_num<=1 -> stay IDLE and pulse pkt_done same cycle as hdr_vld.
REQ-017 Accepted HEAD, context ACTIVE: err_vld code 00, old packet abandoned, new header loaded per REQ-016.
REQ-018 Accepted BODY/TAIL, context IDLE: err_vld code 01, no state change.
REQ-019 Accepted BODY, ACTIVE: remaining decrements; BODY with remaining==1 -> err code 10, context IDLE.
REQ-020 Accepted TAIL, ACTIVE: remaining==1 -> pkt_done, IDLE; remaining!=1 -> err code 10, IDLE, no pkt_done.
REQ-021 All outputs registered; latency exactly one cycle from acceptance; no flit ignored when accepted, one flit per cycle maximum.
REQ-022 Flits with id_valid&~id_ready change nothing.
REQ-023 Unknown type code: ignored, no error.
REQ-024 Counter never wraps below 0; stored tid mismatch on upper bits is treated as same context (aliasing is the sender's responsibility).

Reset
REQ-025 On rst all contexts IDLE, counters 0, ctx_busy 0, all pulses 0, header outputs 0.
REQ-026 rst mid-packet discards the packet silently; the next cycle behaves as post-reset.

Configuration
REQ-027 Macro RPU_IBD_ERR_CNT_EN: defined -> extra output err_cnt (16 bits, saturating at 16'hFFFF, cleared by rst, incremented per err_vld); undefined -> port and counter absent, other behaviour identical.

Structure
REQ-028 Package nou_ibd_pkg holds flit type constants (HEAD/BODY/TAIL), err_code enum, header field struct and bit-position constants.
REQ-029 One sub-module rpu_ibd_ctx instantiated NUM_CTX times, holding one context FSM and counter.

Verification
REQ-030 HEAD tid=2 flit_num=3, BODY, TAIL -> hdr_vld ctx 2 cycle+1, ctx_busy[2]=1, pkt_done ctx 2 one cycle after TAIL.
REQ-031 HEAD flit_num=1 -> hdr_vld and pkt_done same cycle, ctx_busy stays 0.
REQ-032 HEAD tid=0 flit_num=4, HEAD tid=0 again -> err code 00, remaining reloaded to 3.
REQ-033 TAIL tid=1 with no head -> err code 01; HEAD flit_num=4 then TAIL -> err code 10, no pkt_done.
REQ-034 Interleaved tid 0..3 packets with id_ready toggling -> four pkt_done, no errors.
REQ-035 rst asserted mid-packet -> all outputs 0 next cycle; subsequent BODY -> err code 01; with RPU_IBD_ERR_CNT_EN, err_cnt=1.
